au16_mul_seq: RTL and testbench

- Iterative 16x16 multiply sequencer that sits directly upstream of the 16-bit add/subtract unit.
- Each RUN cycle it drives that unit's operands and op-select, then consumes its result and flags to shift-accumulate a 32-bit product.
- Supports unsigned and two's-complement signed operands, with a valid/ready handshake on both the request and result sides.
- One multiply at a time, no pipelining; the adder itself stays purely combinational.

---
 rtl/au_pkg.sv | 18 +
 rtl/au16_mul_seq.sv | 111 +++++++++++
 tb/tb_au16_mul_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/au_pkg.sv
// Shared definitions for the multiply sequencer and its neighbouring add/sub unit.
package au_pkg;

    // Datapath width of the add/subtract unit.
    localparam int AU_W = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Adder op-select encodings.
    localparam logic AU_ADD = 1'b0;
    localparam logic AU_SUB = 1'b1;

endpackage

// File: rtl/au16_mul_seq.sv
// Iterative shift-add multiplier that borrows the external 16-bit add/sub unit.
// Each RUN cycle adds (Q[0] ? M : 0) to the high half P, then shifts {P,Q}
// right by one. The bit shifted into P[15] comes from the adder's carry for
// unsigned operands, or from its true-sign flag for signed ones. A signed
// multiplier's sign bit carries negative weight, so the last step subtracts.
module au16_mul_seq
    import au_pkg::*;
#(
    parameter int W     = 16,
    parameter int STEPS = W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              start_signed,
    input  logic [W-1:0]      start_a,
    input  logic [W-1:0]      start_b,
    output logic [W-1:0]      au_a,
    output logic [W-1:0]      au_b,
    output logic              au_op_sel,
    input  logic [W-1:0]      au_res,
    input  logic              au_c,
    input  logic              au_n,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out_prod,
    output logic              out_zero
);

    // The sequencer is tied to the adder it drives; reject any other width.
    generate
        if (W != AU_W) begin : g_bad_width
            $error("au16_mul_seq: W must equal AU_W (16)");
        end
    endgenerate

    localparam int CW = $clog2(STEPS) + 1;

    state_e        state_q, state_d;
    logic [W-1:0]  m_q, p_q, q_q;
    logic          sgn_q;
    logic [CW-1:0] cnt_q;
    logic          last_step;
    logic          sh;

    assign last_step = (cnt_q == CW'(STEPS - 1));
    // Bit 16 of the partial sum: carry when unsigned, true sign when signed.
    assign sh        = sgn_q ? au_n : au_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_valid) state_d = RUN;
            RUN:     if (last_step)   state_d = DONE;
            DONE:    if (out_ready)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Handshake and adder-drive outputs; the adder sees zeros outside RUN.
    always_comb begin
        start_ready = 1'b0;
        out_valid   = 1'b0;
        au_a        = '0;
        au_b        = '0;
        au_op_sel   = AU_ADD;
        unique case (state_q)
            IDLE: start_ready = 1'b1;
            RUN: begin
                au_a      = p_q;
                au_b      = q_q[0] ? m_q : '0;
                au_op_sel = (sgn_q && q_q[0] && last_step) ? AU_SUB : AU_ADD;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand load on accept, shift-accumulate while running; held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            p_q   <= '0;
            q_q   <= '0;
            sgn_q <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == IDLE && start_valid) begin
            m_q   <= start_a;
            q_q   <= start_b;
            p_q   <= '0;
            sgn_q <= start_signed;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            p_q   <= {sh, au_res[W-1:1]};
            q_q   <= {au_res[0], q_q[W-1:1]};
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign out_prod = {p_q, q_q};
    assign out_zero = (state_q == DONE) && ({p_q, q_q} == '0);

endmodule

// File: tb/tb_au16_mul_seq.sv
// Bench for au16_mul_seq: behavioural adder beside the DUT, a cycle-level
// transaction model, a per-cycle compare process, and directed/random stimulus.
module tb_au16_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic        start_signed = 1'b0;
    logic [15:0] start_a = '0;
    logic [15:0] start_b = '0;
    logic [15:0] au_a, au_b, au_res;
    logic        au_op_sel, au_c, au_n;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_prod;
    logic        out_zero;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    au16_mul_seq #(.W(16), .STEPS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_signed(start_signed), .start_a(start_a), .start_b(start_b),
        .au_a(au_a), .au_b(au_b), .au_op_sel(au_op_sel),
        .au_res(au_res), .au_c(au_c), .au_n(au_n),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_zero(out_zero)
    );

    // Behavioural add/sub unit obeying the adder contract.
    logic [16:0] u17, s17;
    always_comb begin
        if (au_op_sel) begin
            u17 = {1'b0, au_a} + {1'b0, ~au_b} + 17'd1;
            s17 = {au_a[15], au_a} - {au_b[15], au_b};
        end else begin
            u17 = {1'b0, au_a} + {1'b0, au_b};
            s17 = {au_a[15], au_a} + {au_b[15], au_b};
        end
        au_res = u17[15:0];
        au_c   = u17[16];
        au_n   = s17[16];
    end

    function automatic logic [31:0] prod(input bit sg, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa, sb;
        if (sg) begin
            sa = $signed({{16{a[15]}}, a});
            sb = $signed({{16{b[15]}}, b});
            return 32'(sa * sb);
        end
        return {16'd0, a} * {16'd0, b};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Transaction model: cycles of work left, product pending, captured request.
    int          m_rem  = 0;
    bit          m_done = 1'b0;
    bit          m_sgn  = 1'b0;
    logic [15:0] m_a = '0, m_b = '0;
    logic [31:0] m_exp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  = 0;
            m_done = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (start_valid) begin
            m_rem = 16;
            m_sgn = start_signed;
            m_a   = start_a;
            m_b   = start_b;
            m_exp = prod(start_signed, start_a, start_b);
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        check("start_ready", 32'(start_ready), 32'(m_rem == 0 && !m_done));
        check("out_valid", 32'(out_valid), 32'(m_done));
        if (m_done) begin
            check("out_prod", out_prod, m_exp);
            check("out_zero", 32'(out_zero), 32'(m_exp == 0));
        end
        if (m_rem > 0) begin
            check("au_op_sel", 32'(au_op_sel), 32'(m_sgn && m_b[15] && m_rem == 1));
            check("au_b_sel", 32'(au_b == 16'd0 || au_b == m_a), 32'd1);
        end else begin
            check("au_idle", {au_a, au_b[14:0], au_op_sel}, 32'd0);
        end
    end

    // One request end to end; called just after a rising edge.
    task automatic do_mul(input bit sg, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] expv, input int hold, input string nm);
        int          lat;
        logic [31:0] snap;
        start_signed = sg;
        start_a      = a;
        start_b      = b;
        start_valid  = 1'b1;
        lat = 0;
        while (!start_ready && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({nm, " accept_wait"}, 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'd16);
        check({nm, " prod"}, out_prod, expv);
        check({nm, " zero"}, 32'(out_zero), 32'(expv == 0));
        snap = out_prod;
        repeat (hold) begin
            @(posedge clk); #1;
            check({nm, " hold_prod"}, out_prod, snap);
            check({nm, " hold_valid"}, 32'(out_valid), 32'd1);
            check({nm, " hold_busy"}, 32'(start_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, " drained"}, 32'(out_valid), 32'd0);
        check({nm, " back_idle"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [15:0] ra, rb;
        bit rs;

        // Reset state, before any clock edge.
        #1;
        check("rst start_ready", 32'(start_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_prod", out_prod, 32'd0);
        check("rst out_zero", 32'(out_zero), 32'd0);
        check("rst au", {au_a, au_b[14:0], au_op_sel}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-computed products.
        do_mul(1'b0, 16'd3,    16'd5,    32'h0000000F, 0, "u3x5");
        do_mul(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, "uFFFFxFFFF");
        do_mul(1'b1, 16'hFFFD, 16'd5,    32'hFFFFFFF1, 0, "s-3x5");
        do_mul(1'b1, 16'd5,    16'hFFFD, 32'hFFFFFFF1, 0, "s5x-3");
        do_mul(1'b1, 16'h8000, 16'h8000, 32'h40000000, 0, "s8000x8000");
        do_mul(1'b0, 16'd0,    16'h1234, 32'h00000000, 5, "zero_bp");

        // Busy ignore: a second request raised mid-run waits for the first.
        start_signed = 1'b0; start_a = 16'd9; start_b = 16'd11; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start_a = 16'd7; start_b = 16'd7; start_valid = 1'b1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("busy first_prod", out_prod, 32'd99);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("busy turnaround_idle", 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("busy second_lat", 32'(lat), 32'd16);
        check("busy second_prod", out_prod, 32'h00000031);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during RUN cycle 8.
        start_signed = 1'b0; start_a = 16'd300; start_b = 16'd400; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midrun busy", 32'(start_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrun rst ready", 32'(start_ready), 32'd1);
        check("midrun rst valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        lat = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        check("midrun no_pulse", 32'(lat), 32'd0);
        do_mul(1'b0, 16'd2, 16'd2, 32'h00000004, 0, "after_rst");

        // Randomized requests, with occasional corner operands and backpressure.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'h8000;
                1: rb = 16'hFFFF;
                2: ra = 16'h0000;
                3: rb = 16'h7FFF;
                default: ;
            endcase
            do_mul(rs, ra, rb, prod(rs, ra, rb), int'($urandom_range(0, 3)), "rand");
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
